imem_uart_loader: RTL and testbench
===================================

Name: imem_uart_loader

Overview:
UART boot loader that writes program words into instruction memory; the fetch stage later reads them.
- Consumes bytes from the UART receiver and frames them into 32-bit little-endian words.
- Issues single-cycle write strobes to the instruction-memory write port.
- Holds the core in reset (PC at 0) until a complete image is loaded, then releases it.

Parameters:
- ADDR_W, 32, width of instruction-memory byte address.
- MEM_WORDS, 256, instruction-memory capacity in 32-bit words; longer images are rejected.
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 100000, maximum idle cycles between bytes inside a frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe per received byte; if held high, one byte is counted per cycle.
- imem_we  out  1  instruction-memory write enable, one cycle per word.
- imem_addr  out  ADDR_W  byte address of the write, word aligned.
- imem_wdata  out  32  word to write.
- cpu_hold  out  1  high keeps the core (fetch PC register included) in reset.
- load_done  out  1  image fully written.
- load_err  out  1  frame aborted (length or timeout).
- words_loaded  out  16  count of words written in the current frame.

Behaviour:
- Reset (rst=0, async): state IDLE; imem_we=0; imem_addr=BASE_ADDR; imem_wdata=0; cpu_hold=1; load_done=0; load_err=0; words_loaded=0; byte index=0; timeout counter=0.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI (16-bit word count N), then 4*N data bytes, LSB first per word.
- IDLE: on rx_valid with rx_data==SYNC_BYTE go to LEN0. All other bytes are ignored.
- LEN0: on rx_valid latch LEN[7:0], then go to LEN1.
- LEN1: on rx_valid latch LEN[15:8], then evaluate the complete length:
  - N==0: go to DONE.
  - N>MEM_WORDS: go to ERR.
  - Otherwise: go to DATA with words_loaded=0 and byte index=0.
- DATA:
  - Byte k (k=0..3) lands in imem_wdata[8k+7:8k].
  - On the 4th byte, imem_we=1 on the next cycle for exactly one cycle, with imem_addr=BASE_ADDR+4*words_loaded and the assembled word.
  - words_loaded increments in the same cycle imem_we is high.
  - imem_addr/imem_wdata are stable while imem_we=1.
  - The cycle after the write of word N-1, go to DONE.
- DONE:
  - load_done=1 and cpu_hold=0, registered; valid the cycle after the final imem_we.
  - A SYNC_BYTE in DONE restarts a load: cpu_hold=1, load_done=0, go to LEN0.
  - Non-sync bytes are ignored, so program UART traffic does not disturb the loader.
- ERR:
  - load_err=1 and cpu_hold=1.
  - SYNC_BYTE clears load_err and goes to LEN0.
  - Words already written are not rolled back.
- Timeout:
  - In LEN0/LEN1/DATA the counter increments each cycle without rx_valid and clears on rx_valid.
  - Reaching TIMEOUT goes to ERR.
  - If rx_valid and expiry coincide, the byte wins and the counter clears.
  - The counter is held at 0 in IDLE/DONE/ERR.
- Back-to-back bytes (rx_valid every cycle) are accepted without loss. The write cycle never stalls byte capture, because the write uses registered copies.
- imem_we is never asserted outside DATA. Address is never beyond BASE_ADDR+4*(MEM_WORDS-1).
- Reset mid-frame aborts immediately. Partially written memory contents are left as is.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum (IDLE, LEN0, LEN1, DATA, DONE, ERR);
  - the default SYNC_BYTE;
  - LEN_W=16;
  - a function computing the byte address from the word index.
- Sub-module loader_timeout holds the idle counter: inputs clk, rst, enable, kick; output expired; parameter TIMEOUT.
- The FSM and word assembly stay in the top.

Test Plan:
1. Reset: rst low then high, no bytes -> cpu_hold=1, imem_we=0, load_done=0, load_err=0, imem_addr=0.
2. Normal load: send A5 02 00 13 00 00 00 93 00 10 00 -> imem_we pulses twice: (addr 0x0, data 0x00000013) then (addr 0x4, data 0x00100093). The cycle after the second pulse, load_done=1, cpu_hold=0, words_loaded=2.
3. Noise before sync: bytes 00 FF 5A, then a valid 1-word frame -> noise ignored; exactly one write at addr 0.
4. Oversize: A5 01 01 (N=257, MEM_WORDS=256) -> load_err=1, cpu_hold=1, no imem_we; following data bytes ignored until the next A5.
5. Timeout with TIMEOUT=16: A5 01 00 13 00, then 16 idle cycles -> load_err=1, no write. Then A5 01 00 13 00 00 00 -> load_err cleared, write (0x0, 0x00000013), load_done=1.
6. Reset mid-DATA: during a 3-word frame, pull rst low after word 1 is written -> all outputs return to reset values at once. A fresh frame restarts at addr 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the UART instruction-memory boot loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN0,
      LEN1,
      DATA,
      DONE,
      ERR
   } load_state_e;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
   localparam int         LEN_W             = 16;

   function automatic logic [31:0] word_byte_addr(input logic [31:0]      base,
                                                  input logic [LEN_W-1:0] idx);
      return base + (32'(idx) << 2);
   endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle watchdog for an in-progress frame; fires on the TIMEOUT-th idle cycle.
module loader_timeout #(
   parameter int TIMEOUT = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic kick,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] idle_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idle_cnt <= '0;
      end else if (!enable || kick) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + CNT_W'(1);
      end
   end

   // NOTE: a byte arriving on the expiry cycle masks the expiry, so the byte wins.
   assign expired = enable && !kick && (idle_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/imem_uart_loader.sv
// UART boot loader: frames SYNC/LEN/data bytes into little-endian words and writes imem.
module imem_uart_loader
   import imem_loader_pkg::*;
#(
   parameter int               ADDR_W    = 32,
   parameter int               MEM_WORDS = 256,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter logic [7:0]       SYNC_BYTE = DEFAULT_SYNC_BYTE,
   parameter int               TIMEOUT   = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err,
   output logic [15:0]       words_loaded
);

   localparam logic [LEN_W:0] MAX_WORDS = (LEN_W + 1)'(MEM_WORDS);

   load_state_e      state;
   logic [7:0]       len_lo;
   logic [LEN_W-1:0] frame_len;
   logic [1:0]       byte_idx;
   logic [LEN_W-1:0] len_rx;
   logic             is_sync;
   logic             last_written;
   logic             tmo_en;
   logic             tmo_expired;

   assign len_rx       = {rx_data, len_lo};
   assign is_sync      = rx_valid && (rx_data == SYNC_BYTE);
   assign last_written = imem_we && (words_loaded == frame_len);
   assign tmo_en       = (state == LEN0) || (state == LEN1) || (state == DATA);

   loader_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .enable  (tmo_en),
      .kick    (rx_valid),
      .expired (tmo_expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         len_lo       <= '0;
         frame_len    <= '0;
         byte_idx     <= '0;
         imem_we      <= 1'b0;
         imem_addr    <= BASE_ADDR;
         imem_wdata   <= '0;
         cpu_hold     <= 1'b1;
         load_done    <= 1'b0;
         load_err     <= 1'b0;
         words_loaded <= '0;
      end else begin
         // NOTE: default-low every cycle makes imem_we a single-cycle pulse per word.
         imem_we <= 1'b0;
         if (tmo_expired) begin
            state    <= ERR;
            load_err <= 1'b1;
            cpu_hold <= 1'b1;
         end else begin
            case (state)
               IDLE: if (is_sync) state <= LEN0;
               LEN0: if (rx_valid) begin
                  len_lo <= rx_data;
                  state  <= LEN1;
               end
               LEN1: if (rx_valid) begin
                  frame_len <= len_rx;
                  if (len_rx == '0) begin
                     state     <= DONE;
                     load_done <= 1'b1;
                     cpu_hold  <= 1'b0;
                  end else if ({1'b0, len_rx} > MAX_WORDS) begin
                     state    <= ERR;
                     load_err <= 1'b1;
                  end else begin
                     state        <= DATA;
                     words_loaded <= '0;
                     byte_idx     <= '0;
                  end
               end
               DATA: begin
                  // The write cycle of the last word hands over to DONE; bytes there are not data.
                  if (last_written) begin
                     state     <= DONE;
                     load_done <= 1'b1;
                     cpu_hold  <= 1'b0;
                  end else if (rx_valid) begin
                     imem_wdata[8*byte_idx +: 8] <= rx_data;
                     byte_idx <= byte_idx + 2'd1;
                     if (byte_idx == 2'd3) begin
                        imem_we      <= 1'b1;
                        imem_addr    <= ADDR_W'(word_byte_addr(32'(BASE_ADDR), words_loaded));
                        words_loaded <= words_loaded + 16'd1;
                     end
                  end
               end
               DONE: if (is_sync) begin
                  state     <= LEN0;
                  load_done <= 1'b0;
                  cpu_hold  <= 1'b1;
               end
               ERR: if (is_sync) begin
                  state    <= LEN0;
                  load_err <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Self-checking bench for imem_uart_loader with a frame-parsing reference model.
module tb_imem_uart_loader;

   localparam int         TMO  = 16;
   localparam logic [7:0] SYNC = 8'hA5;

   typedef logic [7:0]  byte_q_t[$];
   typedef logic [31:0] word_q_t[$];

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        load_done;
   logic        load_err;
   logic [15:0] words_loaded;

   int total = 0;
   int bad   = 0;

   int      cyc = 0;
   word_q_t wr_addr_q;
   word_q_t wr_data_q;
   int      wr_cyc_q[$];
   int      done_rise_cyc = -1;
   logic    prev_done = 1'b0;

   imem_uart_loader #(
      .ADDR_W    (32),
      .MEM_WORDS (256),
      .BASE_ADDR (32'h0000_0000),
      .SYNC_BYTE (SYNC),
      .TIMEOUT   (TMO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .cpu_hold     (cpu_hold),
      .load_done    (load_done),
      .load_err     (load_err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   // Write and done-edge monitor, sampled mid-cycle.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (imem_we === 1'b1) begin
         wr_addr_q.push_back(imem_addr);
         wr_data_q.push_back(imem_wdata);
         wr_cyc_q.push_back(cyc);
      end
      if (load_done === 1'b1 && prev_done !== 1'b1) done_rise_cyc = cyc;
      prev_done = load_done;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   // Reference: parse complete frames from a byte stream, as seen from IDLE/DONE/ERR.
   function automatic void model(input byte_q_t q, output word_q_t ea, output word_q_t ed,
                                 output bit done, output bit err, output int nwords);
      int i;
      int n;
      ea = {}; ed = {}; done = 0; err = 0; nwords = 0;
      i = 0;
      while (i < q.size()) begin
         if (q[i] != SYNC) begin
            i++;
            continue;
         end
         if (i + 2 >= q.size()) break;
         n = int'(q[i+1]) + 256 * int'(q[i+2]);
         i += 3;
         done = 0; err = 0;
         if (n == 0) begin
            done = 1; nwords = 0;
         end else if (n > 256) begin
            err = 1;
         end else begin
            for (int w = 0; w < n; w++) begin
               ea.push_back(32'(4 * w));
               ed.push_back({q[i+4*w+3], q[i+4*w+2], q[i+4*w+1], q[i+4*w]});
            end
            i += 4 * n;
            done = 1; nwords = n;
         end
      end
   endfunction

   task automatic send_bytes(input byte_q_t q, input bit random_gaps);
      int gap;
      foreach (q[i]) begin
         @(negedge clk);
         rx_valid = 1'b1;
         rx_data  = q[i];
         gap = random_gaps ? int'($urandom_range(0, 3)) : 0;
         if (gap > 0) begin
            @(negedge clk);
            rx_valid = 1'b0;
            repeat (gap - 1) @(negedge clk);
         end
      end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   function automatic logic [7:0] rand_byte(input bit no_sync);
      logic [7:0] b;
      b = 8'($urandom);
      if (no_sync && b == SYNC) b = 8'h3C;
      return b;
   endfunction

   task automatic apply_reset();
      rx_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      apply_reset();
      repeat (3) @(negedge clk);
      total++;
      if ({cpu_hold, imem_we, load_done, load_err} !== 4'b1000) begin
         $display("FAIL reset_flags: got hold/we/done/err=%b want 1000",
                  {cpu_hold, imem_we, load_done, load_err});
         bad++;
      end
      total++;
      if (imem_addr !== 32'h0 || words_loaded !== 16'h0 || imem_wdata !== 32'h0) begin
         $display("FAIL reset_regs: addr=%h words=%0d wdata=%h want 0/0/0",
                  imem_addr, words_loaded, imem_wdata);
         bad++;
      end
   endtask

   task automatic test_normal_load();
      int      base;
      byte_q_t q;
      base = wr_addr_q.size();
      q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      send_bytes(q, 1'b0);
      repeat (3) @(negedge clk);
      total++;
      if (wr_addr_q.size() - base != 2) begin
         $display("FAIL normal_count: got %0d writes want 2", wr_addr_q.size() - base);
         bad++;
      end else begin
         total++;
         if (wr_addr_q[base] !== 32'h0 || wr_data_q[base] !== 32'h0000_0013) begin
            $display("FAIL normal_w0: got %h/%h want 00000000/00000013",
                     wr_addr_q[base], wr_data_q[base]);
            bad++;
         end
         total++;
         if (wr_addr_q[base+1] !== 32'h4 || wr_data_q[base+1] !== 32'h0010_0093) begin
            $display("FAIL normal_w1: got %h/%h want 00000004/00100093",
                     wr_addr_q[base+1], wr_data_q[base+1]);
            bad++;
         end
         total++;
         if (wr_cyc_q[base+1] - wr_cyc_q[base] != 4) begin
            $display("FAIL normal_spacing: got %0d cycles want 4",
                     wr_cyc_q[base+1] - wr_cyc_q[base]);
            bad++;
         end
         total++;
         if (done_rise_cyc != wr_cyc_q[base+1] + 1) begin
            $display("FAIL normal_done_timing: done at %0d want %0d",
                     done_rise_cyc, wr_cyc_q[base+1] + 1);
            bad++;
         end
      end
      total++;
      if ({load_done, cpu_hold, load_err} !== 3'b100 || words_loaded !== 16'd2) begin
         $display("FAIL normal_final: done/hold/err=%b words=%0d want 100 words=2",
                  {load_done, cpu_hold, load_err}, words_loaded);
         bad++;
      end
   endtask

   task automatic test_noise();
      int      base;
      byte_q_t q;
      word_q_t ea, ed;
      bit      done, err;
      int      nw;
      apply_reset();
      base = wr_addr_q.size();
      q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00};
      repeat (4) q.push_back(rand_byte(1'b0));
      model(q, ea, ed, done, err, nw);
      send_bytes(q, 1'b1);
      repeat (3) @(negedge clk);
      total++;
      if (wr_addr_q.size() - base != 1) begin
         $display("FAIL noise_count: got %0d writes want 1", wr_addr_q.size() - base);
         bad++;
      end else begin
         total++;
         if (wr_addr_q[base] !== 32'h0 || wr_data_q[base] !== ed[0]) begin
            $display("FAIL noise_w0: got %h/%h want 00000000/%h",
                     wr_addr_q[base], wr_data_q[base], ed[0]);
            bad++;
         end
      end
      total++;
      if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin
         $display("FAIL noise_done: done=%b hold=%b want 1/0", load_done, cpu_hold);
         bad++;
      end
   endtask

   task automatic test_random_loads();
      for (int r = 0; r < 4; r++) begin
         int      base;
         int      n;
         int      errs;
         byte_q_t q;
         word_q_t ea, ed;
         bit      done, err;
         int      nw;
         base = wr_addr_q.size();
         n = int'($urandom_range(1, 6));
         q = {};
         repeat ($urandom_range(0, 2)) q.push_back(rand_byte(1'b1));
         q.push_back(SYNC);
         q.push_back(8'(n));
         q.push_back(8'h00);
         repeat (4 * n) q.push_back(rand_byte(1'b0));
         model(q, ea, ed, done, err, nw);
         send_bytes(q, 1'b1);
         repeat (3) @(negedge clk);
         errs = 0;
         if (wr_addr_q.size() - base != ea.size()) begin
            errs = 1;
         end else begin
            foreach (ea[k])
               if (wr_addr_q[base+k] !== ea[k] || wr_data_q[base+k] !== ed[k]) errs++;
         end
         total++;
         if (errs != 0) begin
            $display("FAIL random_writes[%0d]: %0d writes, %0d wrong, want %0d writes",
                     r, wr_addr_q.size() - base, errs, ea.size());
            bad++;
         end
         total++;
         if (load_done !== done || load_err !== err || words_loaded !== 16'(nw)) begin
            $display("FAIL random_status[%0d]: done=%b err=%b words=%0d want %b/%b/%0d",
                     r, load_done, load_err, words_loaded, done, err, nw);
            bad++;
         end
      end
   endtask

   task automatic test_length_bounds();
      int          base;
      int          errs;
      byte_q_t     q;
      word_q_t     ea, ed;
      bit          done, err;
      int          nw;
      logic [31:0] w;
      // Oversize: N=257 must be rejected and following data ignored.
      base = wr_addr_q.size();
      q = '{8'hA5, 8'h01, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
      send_bytes(q, 1'b0);
      repeat (2) @(negedge clk);
      total++;
      if ({load_err, cpu_hold, load_done} !== 3'b110 || wr_addr_q.size() != base) begin
         $display("FAIL oversize: err/hold/done=%b writes=%0d want 110 writes=0",
                  {load_err, cpu_hold, load_done}, wr_addr_q.size() - base);
         bad++;
      end
      // Recovery after error.
      w = $urandom;
      q = '{8'hA5, 8'h01, 8'h00, w[7:0], w[15:8], w[23:16], w[31:24]};
      send_bytes(q, 1'b1);
      repeat (3) @(negedge clk);
      total++;
      if (wr_addr_q.size() - base != 1 || load_err !== 1'b0 || load_done !== 1'b1) begin
         $display("FAIL err_recover: writes=%0d err=%b done=%b want 1/0/1",
                  wr_addr_q.size() - base, load_err, load_done);
         bad++;
      end else begin
         total++;
         if (wr_addr_q[base] !== 32'h0 || wr_data_q[base] !== w) begin
            $display("FAIL err_recover_w: got %h/%h want 00000000/%h",
                     wr_addr_q[base], wr_data_q[base], w);
            bad++;
         end
      end
      // Zero-length frame completes with no writes.
      base = wr_addr_q.size();
      q = '{8'hA5, 8'h00, 8'h00};
      send_bytes(q, 1'b0);
      repeat (2) @(negedge clk);
      total++;
      if (wr_addr_q.size() != base || load_done !== 1'b1 || cpu_hold !== 1'b0) begin
         $display("FAIL zero_len: writes=%0d done=%b hold=%b want 0/1/0",
                  wr_addr_q.size() - base, load_done, cpu_hold);
         bad++;
      end
      // Maximum frame: N=MEM_WORDS, back to back.
      base = wr_addr_q.size();
      q = '{8'hA5, 8'h00, 8'h01};
      repeat (4 * 256) q.push_back(rand_byte(1'b0));
      model(q, ea, ed, done, err, nw);
      send_bytes(q, 1'b0);
      repeat (3) @(negedge clk);
      errs = 0;
      if (wr_addr_q.size() - base != 256) begin
         errs = 1;
      end else begin
         foreach (ea[k])
            if (wr_addr_q[base+k] !== ea[k] || wr_data_q[base+k] !== ed[k]) errs++;
      end
      total++;
      if (errs != 0) begin
         $display("FAIL max_frame: %0d writes, %0d wrong, want 256",
                  wr_addr_q.size() - base, errs);
         bad++;
      end
      total++;
      if (wr_addr_q.size() == 0 || wr_addr_q[wr_addr_q.size()-1] !== 32'h3FC ||
          load_done !== 1'b1 || words_loaded !== 16'd256) begin
         $display("FAIL max_frame_end: last_addr=%h done=%b words=%0d want 3fc/1/256",
                  (wr_addr_q.size() != 0) ? wr_addr_q[wr_addr_q.size()-1] : 32'hx,
                  load_done, words_loaded);
         bad++;
      end
   endtask

   task automatic test_timeout();
      int      base;
      byte_q_t q;
      base = wr_addr_q.size();
      q = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00};
      send_bytes(q, 1'b0);
      repeat (TMO - 1) @(negedge clk);
      total++;
      if (load_err !== 1'b0) begin
         $display("FAIL timeout_early: load_err=%b after %0d idle cycles want 0", load_err, TMO - 1);
         bad++;
      end
      @(negedge clk);
      total++;
      if (load_err !== 1'b1 || cpu_hold !== 1'b1 || wr_addr_q.size() != base) begin
         $display("FAIL timeout_fire: err=%b hold=%b writes=%0d want 1/1/0",
                  load_err, cpu_hold, wr_addr_q.size() - base);
         bad++;
      end
      q = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
      send_bytes(q, 1'b0);
      repeat (3) @(negedge clk);
      total++;
      if (wr_addr_q.size() - base != 1 || load_err !== 1'b0 || load_done !== 1'b1) begin
         $display("FAIL timeout_recover: writes=%0d err=%b done=%b want 1/0/1",
                  wr_addr_q.size() - base, load_err, load_done);
         bad++;
      end else begin
         total++;
         if (wr_addr_q[base] !== 32'h0 || wr_data_q[base] !== 32'h0000_0013) begin
            $display("FAIL timeout_recover_w: got %h/%h want 00000000/00000013",
                     wr_addr_q[base], wr_data_q[base]);
            bad++;
         end
      end
   endtask

   task automatic test_reset_mid_data();
      int          base;
      byte_q_t     q;
      logic [31:0] w;
      base = wr_addr_q.size();
      q = '{8'hA5, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
      send_bytes(q, 1'b0);
      @(negedge clk);
      total++;
      if (wr_addr_q.size() - base != 1 || words_loaded !== 16'd1) begin
         $display("FAIL midreset_pre: writes=%0d words=%0d want 1/1",
                  wr_addr_q.size() - base, words_loaded);
         bad++;
      end
      #2 rst = 1'b0;
      #1;
      total++;
      if ({cpu_hold, imem_we, load_done, load_err} !== 4'b1000 || imem_addr !== 32'h0 ||
          imem_wdata !== 32'h0 || words_loaded !== 16'h0) begin
         $display("FAIL midreset_async: hold/we/done/err=%b addr=%h wdata=%h words=%0d want 1000/0/0/0",
                  {cpu_hold, imem_we, load_done, load_err}, imem_addr, imem_wdata, words_loaded);
         bad++;
      end
      @(negedge clk);
      rst = 1'b1;
      base = wr_addr_q.size();
      w = $urandom;
      q = '{8'hA5, 8'h01, 8'h00, w[7:0], w[15:8], w[23:16], w[31:24]};
      send_bytes(q, 1'b1);
      repeat (3) @(negedge clk);
      total++;
      if (wr_addr_q.size() - base != 1 || load_done !== 1'b1) begin
         $display("FAIL midreset_fresh: writes=%0d done=%b want 1/1",
                  wr_addr_q.size() - base, load_done);
         bad++;
      end else begin
         total++;
         if (wr_addr_q[base] !== 32'h0 || wr_data_q[base] !== w) begin
            $display("FAIL midreset_fresh_w: got %h/%h want 00000000/%h",
                     wr_addr_q[base], wr_data_q[base], w);
            bad++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_normal_load();
      test_noise();
      test_random_loads();
      test_length_bounds();
      test_timeout();
      test_reset_mid_data();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
